// File: rtl/flag_branch_unit_if.sv
// rtl/flag_branch_unit_if.sv - execute-side flag inputs and decode-side branch handshake
interface flag_branch_unit_if;
  logic       ex_valid;
  logic [3:0] ex_opcode;
  logic [2:0] alu_flags;
  logic       stall;
  logic       br_valid;
  logic [2:0] br_cond;
  logic       br_ready;
  logic       br_done;
  logic       br_taken;
  logic [2:0] flags_q;

  modport master (
    output ex_valid, ex_opcode, alu_flags, stall, br_valid, br_cond,
    input  br_ready, br_done, br_taken, flags_q
  );

  modport slave (
    input  ex_valid, ex_opcode, alu_flags, stall, br_valid, br_cond,
    output br_ready, br_done, br_taken, flags_q
  );
endinterface

// File: rtl/flag_branch_unit.sv
// rtl/flag_branch_unit.sv - N/Z/V flag register with hazard-aware conditional branch resolution
module flag_branch_unit (
  input  logic              clk,
  input  logic              rst,
  flag_branch_unit_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [2:0] flags;
  logic [2:0] wr_mask;
  logic       commit;
  logic       hazard;
  logic       ready;
  logic       accept;
  logic       cond_met;
  logic       done_q;
  logic       taken_q;

  // Mask bits follow {N,Z,V}; only arithmetic ops touch N and V.
  always_comb begin
    wr_mask = 3'b000;
    case (bus.ex_opcode)
      4'h0, 4'h1:               wr_mask = 3'b111;
      4'h3, 4'h4, 4'h5, 4'h6:   wr_mask = 3'b010;
      default:                  wr_mask = 3'b000;
    endcase
  end

  assign commit = bus.ex_valid & ~bus.stall;
  assign hazard = bus.ex_valid & (|wr_mask) & (bus.br_cond != 3'b111);

  always_comb begin
    cond_met = 1'b0;
    case (bus.br_cond)
      3'b000:  cond_met = ~flags[1];
      3'b001:  cond_met = flags[1];
      3'b010:  cond_met = ~flags[1] & ~flags[2];
      3'b011:  cond_met = flags[2];
      3'b100:  cond_met = flags[1] | (~flags[1] & ~flags[2]);
      3'b101:  cond_met = flags[2] | flags[1];
      3'b110:  cond_met = flags[0];
      default: cond_met = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // HOLD exits on any non-stalled cycle: either the write commits or it was squashed.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.br_valid & hazard) state_nxt = HOLD;
      HOLD:    if (~bus.stall)            state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    if (state == IDLE) ready = ~hazard & ~rst;
  end

  assign accept = bus.br_valid & ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags   <= 3'b000;
      done_q  <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      if (commit) flags <= (flags & ~wr_mask) | (bus.alu_flags & wr_mask);
      done_q  <= accept;
      taken_q <= accept & cond_met;
    end
  end

  assign bus.br_ready = ready;
  assign bus.br_done  = done_q;
  assign bus.br_taken = taken_q;
  assign bus.flags_q  = flags;

endmodule
